// File: rtl/axil_demux_ctrl.sv
// axil_demux_ctrl: AXI-Lite 1-to-N address demux with DECERR for
// unmapped addresses and per-slot response timeout fencing.
module axil_demux_ctrl #(
  parameter int num_slots_p = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter logic [num_slots_p*addr_width_p-1:0] base_addr_p = '0,
  parameter logic [127:0] slot_addr_width_p = {16{8'd12}},
  parameter int timeout_p = 1024,
  localparam int strb_w = data_width_p / 8,
  localparam int mosi_w = 2*addr_width_p + data_width_p + strb_w + 5,
  localparam int miso_w = data_width_p + 9
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [mosi_w-1:0] s_axil_ser_i,
  output logic [miso_w-1:0] s_axil_ser_o,
  output logic [num_slots_p*mosi_w-1:0] m_axil_par_o,
  input  logic [num_slots_p*miso_w-1:0] m_axil_par_i
);

  localparam int sel_w = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;
  localparam logic [31:0] to_last = 32'(timeout_p - 1);
  localparam bit to_en = (timeout_p != 0);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BRSP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_RRSP} r_state_t;

  logic [addr_width_p-1:0] s_awaddr, s_araddr;
  logic [data_width_p-1:0] s_wdata;
  logic [strb_w-1:0] s_wstrb;
  logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

  assign {s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
          s_bready, s_araddr, s_arvalid, s_rready} = s_axil_ser_i;

  logic [num_slots_p-1:0] m_awready, m_wready, m_bvalid;
  logic [num_slots_p-1:0] m_arready, m_rvalid;
  logic [1:0] m_bresp [num_slots_p];
  logic [1:0] m_rresp [num_slots_p];
  logic [data_width_p-1:0] m_rdata [num_slots_p];

  w_state_t w_state;
  r_state_t r_state;
  logic aw_have, w_have, aw_done, w_done;
  logic [addr_width_p-1:0] aw_q, ar_q;
  logic [data_width_p-1:0] wdata_q, rdata_q;
  logic [strb_w-1:0] wstrb_q;
  logic [sel_w-1:0] w_sel, r_sel;
  logic [1:0] bresp_q, rresp_q;
  logic [31:0] w_cnt, r_cnt;
  logic [num_slots_p-1:0] hung;

  // Returns {hit, index}; scanning downward lets the lowest index win.
  function automatic logic [sel_w:0] decode(
    input logic [addr_width_p-1:0] a
  );
    logic [sel_w:0] r;
    logic [7:0] sh;
    r = '0;
    for (int i = num_slots_p - 1; i >= 0; i--) begin
      sh = slot_addr_width_p[i*8 +: 8];
      if ((a >> sh) ==
          (base_addr_p[i*addr_width_p +: addr_width_p] >> sh))
        r = {1'b1, sel_w'(i)};
    end
    return r;
  endfunction

  logic s_awready, s_wready, s_arready;
  logic aw_hs, w_hs, ar_hs, w_both;
  logic [addr_width_p-1:0] w_addr;
  logic [sel_w:0] w_dec, r_dec;
  logic w_fwd_done, w_advance, w_expire;
  logic r_advance, r_expire;

  assign s_awready = (w_state == W_IDLE) && !aw_have;
  assign s_wready = (w_state == W_IDLE) && !w_have;
  assign s_arready = (r_state == R_IDLE);
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;
  assign w_both = (aw_have || aw_hs) && (w_have || w_hs);
  assign w_addr = aw_have ? aw_q : s_awaddr;
  assign w_dec = decode(w_addr);
  assign r_dec = decode(s_araddr);

  assign w_fwd_done = (aw_done || m_awready[w_sel]) &&
                      (w_done || m_wready[w_sel]);
  assign w_advance = ((w_state == W_FWD) && w_fwd_done) ||
                     ((w_state == W_RESP) && m_bvalid[w_sel]);
  assign w_expire = to_en && !w_advance && (w_cnt == to_last) &&
                    ((w_state == W_FWD) || (w_state == W_RESP));
  assign r_advance = ((r_state == R_FWD) && m_arready[r_sel]) ||
                     ((r_state == R_RESP) && m_rvalid[r_sel]);
  assign r_expire = to_en && !r_advance && (r_cnt == to_last) &&
                    ((r_state == R_FWD) || (r_state == R_RESP));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      w_state <= W_IDLE;
      aw_have <= 1'b0;
      w_have <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      aw_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      w_sel <= '0;
      bresp_q <= '0;
      w_cnt <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_q <= s_awaddr;
            aw_have <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
            w_have <= 1'b1;
          end
          if (w_both) begin
            aw_have <= 1'b0;
            w_have <= 1'b0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            w_cnt <= '0;
            w_sel <= w_dec[sel_w-1:0];
            if (!w_dec[sel_w]) begin
              bresp_q <= 2'b11;
              w_state <= W_BRSP;
            end else if (hung[w_dec[sel_w-1:0]]) begin
              bresp_q <= 2'b10;
              w_state <= W_BRSP;
            end else begin
              w_state <= W_FWD;
            end
          end
        end
        W_FWD: begin
          aw_done <= aw_done || m_awready[w_sel];
          w_done <= w_done || m_wready[w_sel];
          if (w_expire) begin
            bresp_q <= 2'b10;
            w_state <= W_BRSP;
            w_cnt <= '0;
          end else if (w_fwd_done) begin
            w_state <= W_RESP;
            w_cnt <= '0;
          end else begin
            w_cnt <= w_cnt + 32'd1;
          end
        end
        W_RESP: begin
          if (m_bvalid[w_sel]) begin
            bresp_q <= m_bresp[w_sel];
            w_state <= W_BRSP;
            w_cnt <= '0;
          end else if (w_expire) begin
            bresp_q <= 2'b10;
            w_state <= W_BRSP;
            w_cnt <= '0;
          end else begin
            w_cnt <= w_cnt + 32'd1;
          end
        end
        W_BRSP: begin
          if (s_bready) w_state <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= R_IDLE;
      ar_q <= '0;
      r_sel <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_q <= s_araddr;
            r_sel <= r_dec[sel_w-1:0];
            r_cnt <= '0;
            rdata_q <= '0;
            if (!r_dec[sel_w]) begin
              rresp_q <= 2'b11;
              r_state <= R_RRSP;
            end else if (hung[r_dec[sel_w-1:0]]) begin
              rresp_q <= 2'b10;
              r_state <= R_RRSP;
            end else begin
              r_state <= R_FWD;
            end
          end
        end
        R_FWD: begin
          if (r_expire) begin
            rresp_q <= 2'b10;
            r_state <= R_RRSP;
            r_cnt <= '0;
          end else if (m_arready[r_sel]) begin
            r_state <= R_RESP;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        R_RESP: begin
          if (m_rvalid[r_sel]) begin
            rdata_q <= m_rdata[r_sel];
            rresp_q <= m_rresp[r_sel];
            r_state <= R_RRSP;
            r_cnt <= '0;
          end else if (r_expire) begin
            rresp_q <= 2'b10;
            r_state <= R_RRSP;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        R_RRSP: begin
          if (s_rready) r_state <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hung <= '0;
    end else begin
      if (w_expire) hung[w_sel] <= 1'b1;
      if (r_expire) hung[r_sel] <= 1'b1;
    end
  end

  assign s_axil_ser_o = reset_n_i ?
    {s_awready, s_wready, bresp_q, (w_state == W_BRSP),
     s_arready, rdata_q, rresp_q, (r_state == R_RRSP)} : '0;

  for (genvar i = 0; i < num_slots_p; i++) begin : g_slot
    logic ws, rs, awv, wv, bry, arv, rry;
    assign ws = (w_sel == sel_w'(i));
    assign rs = (r_sel == sel_w'(i));
    assign awv = (w_state == W_FWD) && ws && !aw_done;
    assign wv = (w_state == W_FWD) && ws && !w_done;
    // Fenced slots keep their ready high to drain late responses.
    assign bry = ((w_state == W_RESP) && ws) || hung[i];
    assign arv = (r_state == R_FWD) && rs;
    assign rry = ((r_state == R_RESP) && rs) || hung[i];
    assign m_axil_par_o[i*mosi_w +: mosi_w] = reset_n_i ?
      {aw_q, awv, wdata_q, wstrb_q, wv, bry, ar_q, arv, rry} : '0;
    assign {m_awready[i], m_wready[i], m_bresp[i], m_bvalid[i],
            m_arready[i], m_rdata[i], m_rresp[i], m_rvalid[i]} =
      m_axil_par_i[i*miso_w +: miso_w];
  end

endmodule

// File: tb/tb_axil_demux_ctrl.sv
// tb_axil_demux_ctrl: directed bench for the AXI-Lite demux with
// simple per-slot responders.
module tb_axil_demux_ctrl;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MOSI = 2*AW + DW + SW + 5;
  localparam int MISO = DW + 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MOSI-1:0] s_in;
  logic [MISO-1:0] s_out;
  logic [NS*MOSI-1:0] m_out;
  logic [NS*MISO-1:0] m_in;

  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;

  assign s_in = {awaddr, awvalid, wdata, wstrb, wvalid, bready,
                 araddr, arvalid, rready};

  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;
  assign {s_awready, s_wready, s_bresp, s_bvalid, s_arready,
          s_rdata, s_rresp, s_rvalid} = s_out;

  axil_demux_ctrl #(
    .num_slots_p(NS),
    .addr_width_p(AW),
    .data_width_p(DW),
    .base_addr_p({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
    .timeout_p(16)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .s_axil_ser_i(s_in),
    .s_axil_ser_o(s_out),
    .m_axil_par_o(m_out),
    .m_axil_par_i(m_in)
  );

  logic [AW-1:0] m_awaddr [NS];
  logic [AW-1:0] m_araddr [NS];
  logic [DW-1:0] m_wdata [NS];
  logic [SW-1:0] m_wstrb [NS];
  logic [NS-1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  logic [NS-1:0] aw_en = '1;
  logic [NS-1:0] bv = '0, rv = '0, got_aw = '0, got_w = '0;
  logic [1:0] bresp_cfg [NS] = '{2'b10, 2'b00, 2'b00, 2'b00};
  logic [DW-1:0] rd_cfg [NS] =
    '{32'h0000A0A0, 32'h1111B1B1, 32'hCAFE0001, 32'h3333D3D3};

  int cyc = 0;
  int aw_cnt [NS] = '{default: 0};
  int w_cnt [NS] = '{default: 0};
  int arv_seen [NS] = '{default: 0};
  int b_cyc [NS] = '{default: 0};
  logic [AW-1:0] aw_last [NS] = '{default: '0};
  logic [AW-1:0] ar_last [NS] = '{default: '0};
  logic [DW-1:0] wd_last [NS] = '{default: '0};
  logic [SW-1:0] ws_last [NS] = '{default: '0};

  for (genvar gi = 0; gi < NS; gi++) begin : g_m
    assign {m_awaddr[gi], m_awvalid[gi], m_wdata[gi], m_wstrb[gi],
            m_wvalid[gi], m_bready[gi], m_araddr[gi], m_arvalid[gi],
            m_rready[gi]} = m_out[gi*MOSI +: MOSI];
    assign m_in[gi*MISO +: MISO] =
      {aw_en[gi], 1'b1, bresp_cfg[gi], bv[gi], 1'b1,
       rd_cfg[gi], 2'b00, rv[gi]};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++) begin
      if (m_arvalid[i]) begin
        arv_seen[i] <= arv_seen[i] + 1;
        ar_last[i] <= m_araddr[i];
      end
      if (m_awvalid[i] && aw_en[i]) begin
        aw_cnt[i] <= aw_cnt[i] + 1;
        aw_last[i] <= m_awaddr[i];
      end
      if (m_wvalid[i]) begin
        w_cnt[i] <= w_cnt[i] + 1;
        wd_last[i] <= m_wdata[i];
        ws_last[i] <= m_wstrb[i];
      end
      if (bv[i] && m_bready[i]) begin
        bv[i] <= 1'b0;
      end else if (!bv[i] &&
                   (got_aw[i] || (m_awvalid[i] && aw_en[i])) &&
                   (got_w[i] || m_wvalid[i])) begin
        bv[i] <= 1'b1;
        b_cyc[i] <= cyc + 1;
        got_aw[i] <= 1'b0;
        got_w[i] <= 1'b0;
      end else begin
        if (m_awvalid[i] && aw_en[i]) got_aw[i] <= 1'b1;
        if (m_wvalid[i]) got_w[i] <= 1'b1;
      end
      if (m_arvalid[i]) rv[i] <= 1'b1;
      else if (rv[i] && m_rready[i]) rv[i] <= 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic send_aw_w(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic [SW-1:0] s,
                           output int hs);
    bit af, wf;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    for (int k = 0; k < 20 && (awvalid || wvalid); k++) begin
      af = awvalid && s_awready;
      wf = wvalid && s_wready;
      @(negedge clk);
      if (af) awvalid = 0;
      if (wf) wvalid = 0;
    end
    awvalid = 0; wvalid = 0;
    hs = cyc;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, output int hs);
    bit af;
    araddr = a; arvalid = 1;
    for (int k = 0; k < 20 && arvalid; k++) begin
      af = s_arready;
      @(negedge clk);
      if (af) arvalid = 0;
    end
    arvalid = 0;
    hs = cyc;
  endtask

  task automatic wait_b(output int at, output bit ok);
    ok = 0; at = 0;
    for (int k = 0; k < 40; k++) begin
      if (s_bvalid) begin ok = 1; at = cyc; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_r(output int at, output bit ok);
    ok = 0; at = 0;
    for (int k = 0; k < 40; k++) begin
      if (s_rvalid) begin ok = 1; at = cyc; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (s_out !== '0) begin
      fails++; $display("FAIL reset_s_out: got %h want 0", s_out);
    end
    tests++;
    if (m_out !== '0) begin
      fails++; $display("FAIL reset_m_out: got %h want 0", m_out);
    end
    rst_n = 1;
    @(negedge clk);
    tests++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100)
    begin
      fails++;
      $display("FAIL reset_ready: got %b want 11100",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
  endtask

  task automatic test_mapped_write();
    int hs, at, oaw, ow;
    bit ok;
    oaw = aw_cnt[0] + aw_cnt[2] + aw_cnt[3];
    ow = w_cnt[0] + w_cnt[2] + w_cnt[3];
    send_aw_w(32'h1004, 32'hDEADBEEF, 4'hF, hs);
    wait_b(at, ok);
    tests++;
    if (!ok || s_bresp !== 2'b00) begin
      fails++; $display("FAIL wr_bresp: got %b ok=%0d want 00", s_bresp, ok);
    end
    tests++;
    if (at - b_cyc[1] != 1) begin
      fails++; $display("FAIL wr_lat: got %0d want 1", at - b_cyc[1]);
    end
    tests++;
    if (aw_last[1] !== 32'h1004 || wd_last[1] !== 32'hDEADBEEF ||
        ws_last[1] !== 4'hF) begin
      fails++;
      $display("FAIL wr_slot1: got %h/%h/%h want 1004/deadbeef/f",
               aw_last[1], wd_last[1], ws_last[1]);
    end
    tests++;
    if (aw_cnt[0] + aw_cnt[2] + aw_cnt[3] != oaw ||
        w_cnt[0] + w_cnt[2] + w_cnt[3] != ow) begin
      fails++; $display("FAIL wr_others: got traffic want none");
    end
    @(negedge clk);
    tests++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      fails++;
      $display("FAIL wr_done: got bvalid=%b awready=%b want 0 1",
               s_bvalid, s_awready);
    end
  endtask

  task automatic test_mapped_read();
    int hs, at;
    bit ok;
    send_ar(32'h2010, hs);
    wait_r(at, ok);
    tests++;
    if (!ok || at - hs != 2) begin
      fails++; $display("FAIL rd_lat: got %0d ok=%0d want 2", at - hs, ok);
    end
    tests++;
    if (s_rdata !== 32'hCAFE0001 || s_rresp !== 2'b00 ||
        ar_last[2] !== 32'h2010) begin
      fails++;
      $display("FAIL rd_data: got %h/%b/%h want cafe0001/00/2010",
               s_rdata, s_rresp, ar_last[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    int hs, at, seen;
    bit ok;
    seen = arv_seen[0] + arv_seen[1] + arv_seen[2] + arv_seen[3];
    send_ar(32'h8000, hs);
    wait_r(at, ok);
    tests++;
    if (!ok || at - hs > 3 || s_rresp !== 2'b11 || s_rdata !== '0) begin
      fails++;
      $display("FAIL unm_rd: got lat=%0d resp=%b data=%h want <=3/11/0",
               at - hs, s_rresp, s_rdata);
    end
    tests++;
    if (arv_seen[0] + arv_seen[1] + arv_seen[2] + arv_seen[3] != seen)
    begin
      fails++; $display("FAIL unm_arvalid: got slot arvalid want none");
    end
    @(negedge clk);
    send_aw_w(32'h8000, 32'h11112222, 4'hF, hs);
    wait_b(at, ok);
    tests++;
    if (!ok || s_bresp !== 2'b11) begin
      fails++; $display("FAIL unm_wr: got %b ok=%0d want 11", s_bresp, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_order();
    int at, oaw, ow;
    bit ok, bad;
    oaw = aw_cnt[2]; ow = w_cnt[2]; bad = 0;
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (3) begin
      if (s_wready !== 1'b0 || s_awready !== 1'b1) bad = 1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL ord_ready: got wready high want low");
    end
    awaddr = 32'h2008; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    wait_b(at, ok);
    tests++;
    if (!ok || s_bresp !== 2'b00 || aw_cnt[2] != oaw + 1 ||
        w_cnt[2] != ow + 1) begin
      fails++;
      $display("FAIL ord_txn: got ok=%0d bresp=%b aw=%0d w=%0d want 1 txn",
               ok, s_bresp, aw_cnt[2] - oaw, w_cnt[2] - ow);
    end
    tests++;
    if (aw_last[2] !== 32'h2008 || wd_last[2] !== 32'h12345678 ||
        ws_last[2] !== 4'h3) begin
      fails++;
      $display("FAIL ord_data: got %h/%h/%h want 2008/12345678/3",
               aw_last[2], wd_last[2], ws_last[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit bseen, rgot, bad;
    int hold;
    logic [1:0] b0;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    bseen = 0; rgot = 0; bad = 0; hold = 0; b0 = '0; rd = '0; rr = '1;
    bready = 0;
    awaddr = 32'h0040; awvalid = 1;
    wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h0080; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    for (int k = 0; k < 30 && hold < 5; k++) begin
      if (s_rvalid && !rgot) begin
        rgot = 1; rd = s_rdata; rr = s_rresp;
      end
      if (s_bvalid) begin
        if (!bseen) begin
          bseen = 1; b0 = s_bresp;
        end else begin
          hold++;
          if (s_bresp !== b0) bad = 1;
        end
        if (s_awready || s_wready) bad = 1;
      end else if (bseen) begin
        bad = 1;
      end
      @(negedge clk);
    end
    tests++;
    if (!bseen || bad || b0 !== 2'b10) begin
      fails++;
      $display("FAIL bp_bresp: got seen=%0d unstable=%0d resp=%b want 1 0 10",
               bseen, bad, b0);
    end
    tests++;
    if (!rgot || rd !== 32'h0000A0A0 || rr !== 2'b00) begin
      fails++;
      $display("FAIL bp_read: got %0d/%h/%b want 1/0000a0a0/00", rgot, rd, rr);
    end
    bready = 1;
    @(negedge clk);
    tests++;
    if (s_bvalid !== 1'b0) begin
      fails++; $display("FAIL bp_release: got bvalid=1 want 0");
    end
  endtask

  task automatic test_timeout_reset();
    int hs, at, seen;
    bit ok;
    aw_en[3] = 0;
    send_aw_w(32'h3000, 32'h0BADF00D, 4'hF, hs);
    wait_b(at, ok);
    tests++;
    if (!ok || at - hs != 16 || s_bresp !== 2'b10) begin
      fails++;
      $display("FAIL to_wr: got ok=%0d lat=%0d resp=%b want 1/16/10",
               ok, at - hs, s_bresp);
    end
    tests++;
    if (m_awvalid[3] !== 1'b0 || m_bready[3] !== 1'b1) begin
      fails++;
      $display("FAIL to_fence: got awvalid=%b bready=%b want 0 1",
               m_awvalid[3], m_bready[3]);
    end
    @(negedge clk);
    seen = arv_seen[3];
    send_ar(32'h3010, hs);
    wait_r(at, ok);
    tests++;
    if (!ok || at != hs || s_rresp !== 2'b10 || s_rdata !== '0 ||
        arv_seen[3] != seen) begin
      fails++;
      $display("FAIL to_hung_rd: got lat=%0d resp=%b data=%h want 0/10/0",
               at - hs, s_rresp, s_rdata);
    end
    @(negedge clk);
    send_ar(32'h0010, hs);
    wait_r(at, ok);
    tests++;
    if (!ok || s_rresp !== 2'b00 || s_rdata !== 32'h0000A0A0) begin
      fails++;
      $display("FAIL to_slot0: got %b/%h want 00/0000a0a0", s_rresp, s_rdata);
    end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    aw_en[3] = 1;
    @(negedge clk);
    tests++;
    if (m_bready[3] !== 1'b0) begin
      fails++; $display("FAIL rst_unfence: got bready=1 want 0");
    end
    send_aw_w(32'h3004, 32'h600DCAFE, 4'hF, hs);
    wait_b(at, ok);
    tests++;
    if (!ok || s_bresp !== 2'b00 || aw_last[3] !== 32'h3004 ||
        wd_last[3] !== 32'h600DCAFE) begin
      fails++;
      $display("FAIL rst_slot3: got ok=%0d resp=%b addr=%h data=%h want 00",
               ok, s_bresp, aw_last[3], wd_last[3]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mapped_write();
    test_mapped_read();
    test_unmapped();
    test_order();
    test_back_to_back();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
